sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage words (power of 2, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port Clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port EN  input  1  global enable; 0 freezes all state except reset.
REQ-009 SHALL have port WR  input  1  write request.
REQ-010 SHALL have port dataIn  input  DATA_W  write data.
REQ-011 SHALL have port RD  input  1  read request.
REQ-012 SHALL have port dataOut  output  DATA_W  read data.
REQ-013 SHALL have port VALID  output  1  dataOut holds a valid popped/head word.
REQ-014 SHALL have port FULL  output  1  count == DEPTH.
REQ-015 SHALL have port EMPTY  output  1  count == 0.
REQ-016 SHALL have port ALMOST_FULL  output  1  count >= AF_LEVEL.
REQ-017 SHALL have port ALMOST_EMPTY  output  1  count <= AE_LEVEL.
REQ-018 SHALL have port COUNT  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH inclusive.
REQ-019 SHALL have port OVF  output  1  sticky overflow: write attempted when not accepted.
REQ-020 SHALL have port UDF  output  1  sticky underflow: read attempted when not accepted.

Function
REQ-021 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0 with no gap or skip.
REQ-022 SHALL accept a write when EN & WR & (!FULL | read accepted same cycle); store dataIn at write pointer, advance write pointer.
REQ-023 SHALL accept a read when EN & RD & !EMPTY; advance read pointer; an empty FIFO never bypasses same-cycle write data to the read side.
REQ-024 SHALL update COUNT: +1 write-only accepted, -1 read-only accepted, unchanged when both or neither accepted.
REQ-025 SHALL, with FULL and RD&WR both asserted, accept both operations; COUNT stays DEPTH.
REQ-026 SHALL, with EMPTY and RD&WR both asserted, accept the write only; COUNT becomes 1; UDF sets.
REQ-027 SHALL, in FWFT=0, register popped word to dataOut one cycle after the accepted read and set VALID for exactly that cycle; dataOut otherwise holds its last value.
REQ-028 SHALL, in FWFT=1, drive dataOut with the head word and VALID = !EMPTY; RD acts as pop acknowledge; head of an empty FIFO appears the cycle after the accepting write edge.
REQ-029 SHALL derive FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY from the registered COUNT only (no combinational path from RD/WR/dataIn).
REQ-030 SHALL set OVF when EN & WR & write not accepted; set UDF when EN & RD & read not accepted; both cleared only by Rst.
REQ-031 SHALL, with EN=0, ignore RD/WR, hold pointers, COUNT, dataOut, flags; VALID deasserts in FWFT=0.

Reset
REQ-032 SHALL, on Rst=1 at a rising edge regardless of EN, clear pointers, COUNT=0, dataOut=0, VALID=0, OVF=0, UDF=0; EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0 (defaults).
REQ-033 SHALL give Rst priority over same-cycle RD/WR; storage contents need not be cleared; a mid-operation reset discards all held words.

Verification
REQ-034 SHALL pass fill/drain (defaults, FWFT=0): 8 writes 0x1..0x8 -> FULL=1, COUNT=8, ALMOST_FULL from COUNT=6; 8 reads -> dataOut 0x1..0x8 each one cycle after RD, VALID pulses, EMPTY=1.
REQ-035 SHALL pass wrap-around: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> order preserved, COUNT never exceeds 8, no OVF/UDF.
REQ-036 SHALL pass full boundary: at COUNT=8, WR alone -> OVF=1, COUNT=8; then RD&WR with dataIn=0xBEEF -> COUNT=8, 0xBEEF read out last.
REQ-037 SHALL pass empty boundary: EMPTY, RD&WR dataIn=0x55 -> UDF=1, COUNT=1, next RD returns 0x55.
REQ-038 SHALL pass FWFT=1: write 0x11 -> dataOut=0x11, VALID=1 next cycle without RD; RD -> EMPTY=1, VALID=0.
REQ-039 SHALL pass reset/enable: COUNT=3, EN=0 with RD&WR for 4 cycles -> nothing changes; Rst=1 with EN=0 -> COUNT=0, EMPTY=1, OVF=UDF=0.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with occupancy flags and sticky overflow/underflow; read data one cycle after RD (FWFT=0) or head-of-queue (FWFT=1).
// Backpressure: writes are refused when full unless a read is taken the same cycle; reads are refused when empty.
module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     EN,
  input  logic                     WR,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic                     RD,
  output logic [DATA_W-1:0]        dataOut,
  output logic                     VALID,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVF,
  output logic                     UDF
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              rd_ok;
  logic              wr_ok;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_ok = EN & RD & (count != '0);
  assign wr_ok = EN & WR & ((count != DEPTH_C) | rd_ok);

  always_ff @(posedge Clk) begin
    if (!Rst && wr_ok) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      OVF    <= 1'b0;
      UDF    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (EN && WR && !wr_ok) OVF <= 1'b1;
      if (EN && RD && !rd_ok) UDF <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // No head word exists while empty, so the output is parked at zero.
      assign dataOut = EMPTY ? '0 : mem[rd_ptr];
      assign VALID   = !EMPTY;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;
      always_ff @(posedge Clk) begin
        if (Rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr];
        end
      end
      assign dataOut = dout_q;
      assign VALID   = valid_q;
    end
  endgenerate

  assign COUNT        = count;
  assign FULL         = (count == DEPTH_C);
  assign EMPTY        = (count == '0);
  assign ALMOST_FULL  = (count >= AF_C);
  assign ALMOST_EMPTY = (count <= AE_C);

endmodule
